alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Registered issue stage in front of the ALU in the RV32I datapath. Decodes ALUOp/Funct3/Funct7 into the 4-bit ALU Operation code. Carries SrcA/SrcB alongside the decoded code through a two-entry skid buffer with valid/ready handshakes, so decode and execute stall independently. Sits between the ID/EX pipeline register and the ALU. Its output drives the ALU's Operation, SrcA and SrcB inputs directly.

## Interface
- DATA_WIDTH, 32, operand width
- OPCODE_LENGTH, 4, width of Operation output
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous pipeline flush (branch redirect)
- in_valid  in  1  upstream presents an op
- in_ready  out  1  block can accept an op this cycle
- ALUOp  in  2  00 mem-address, 01 branch, 10 R/I arithmetic, 11 LUI
- Funct3  in  3  instruction funct3
- Funct7b5  in  1  instruction bit 30
- IsRType  in  1  1 = R-type, so Funct7b5 selects SUB
- SrcA_in, SrcB_in  in  DATA_WIDTH  operands
- out_valid  out  1  Operation/SrcA/SrcB valid
- out_ready  in  1  ALU stage consumes this cycle
- Operation  out  OPCODE_LENGTH  decoded ALU code
- SrcA, SrcB  out  DATA_WIDTH  operands of head entry
- Illegal  out  1  head entry had an undecodable combination

## Operation
- Decode, evaluated on accept:
  - ALUOp 00: ADD 0010.
  - ALUOp 11: LUI 1001.
  - ALUOp 01, Funct3 000: EQ 1000. Any other Funct3 is illegal.
  - ALUOp 10, Funct3 000: SUB 0011 if IsRType & Funct7b5, else ADD 0010.
  - ALUOp 10, Funct3 100: XOR 0100. Funct3 110: OR 0001. Funct3 111: AND 0000. Any other Funct3 is illegal.
- Illegal op: Operation = 4'b1111 (ALU yields 0), Illegal = 1. The entry still issues normally.
- Buffer states:
  - EMPTY: out_valid 0, in_ready 1.
  - ONE: out_valid 1, in_ready 1.
  - TWO: out_valid 1, in_ready 0.
- Accept when in_valid & in_ready. Pop when out_valid & out_ready.
- State transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept, no pop -> TWO.
  - ONE + pop, no accept -> EMPTY.
  - ONE + accept + pop -> ONE, new entry becomes head.
  - TWO + pop -> ONE, skid entry promoted to head.
- Entries leave strictly in FIFO order.
- flush: next state EMPTY. Any same-cycle accept is discarded, and a same-cycle pop is also treated as discarded.
- Reset has priority over flush. Flush has priority over accept/pop.

## Timing
- Reset values:
  - out_valid 0, in_ready 1 (state EMPTY).
  - Operation 4'b0000, SrcA 0, SrcB 0, Illegal 0.
  - Stat counters 0.
- Latency: accept in cycle N -> out_valid and data at the head in cycle N+1, when the buffer was EMPTY.
- Throughput: one op per cycle while out_ready stays high.
- in_ready is a register output with no combinational path from out_ready. It deasserts the cycle after entering TWO.
- Outputs are registered, with no combinational path from inputs.
- Outputs hold stable while out_valid & !out_ready.
- Reset asserted mid-stall clears both entries in one cycle.

## Configuration
- ALU_ISSUE_STATS_EN defined: adds the following outputs.
  - issued_count [15:0]: increments per pop.
  - illegal_count [15:0]: increments per pop with Illegal = 1.
  - Both saturate at 16'hFFFF, clear on reset only, and are unaffected by flush.
- ALU_ISSUE_STATS_EN undefined: ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package alu_issue_pkg holds:
  - Operation localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_EQ, OP_LUI, OP_ILLEGAL.
  - ALUOp typedef enum: ALUOP_MEM, ALUOP_BR, ALUOP_ARITH, ALUOP_LUI.
  - Buffer state enum: EMPTY, ONE, TWO.
- One combinational sub-module, alu_op_decode: ALUOp/Funct3/Funct7b5/IsRType -> Operation, Illegal.

## Test plan
- Reset, then ALUOp 10, Funct3 000, IsRType 1, Funct7b5 1, SrcA 7, SrcB 3, out_ready 1 -> next cycle out_valid 1, Operation 0011, SrcA 7, SrcB 3.
- Decode sweep: ALUOp 00 -> 0010; 01/000 -> 1000; 11 -> 1001; 10/100 -> 0100; 10/110 -> 0001; 10/111 -> 0000; 10/000 I-type with Funct7b5 1 -> 0010.
- Illegal: ALUOp 10, Funct3 001 -> Operation 1111, Illegal 1. Also ALUOp 01, Funct3 001 -> same.
- Backpressure: out_ready 0, offer 3 ops A,B,C -> A,B accepted, in_ready 0 from the 2nd cycle after first accept. Raise out_ready -> A, B, C emerge in order with no loss or duplication.
- Flush with buffer in TWO plus in_valid the same cycle -> next cycle out_valid 0, in_ready 1, and no flushed op ever appears.
- With ALU_ISSUE_STATS_EN: 5 pops including 2 illegal -> issued_count 5, illegal_count 2. Reset -> both 0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types and ALU operation codes for the ALU issue stage.
// Consumed by alu_op_decode, alu_issue_if and alu_issue_ctrl.
package alu_issue_pkg;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_SUB     = 4'b0011;
  localparam logic [3:0] OP_XOR     = 4'b0100;
  localparam logic [3:0] OP_EQ      = 4'b1000;
  localparam logic [3:0] OP_LUI     = 4'b1001;
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_ARITH = 2'b10,
    ALUOP_LUI   = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_issue_if.sv
// Decode-side and ALU-side handshake bundle of the issue stage.
// master = pipeline around the block, slave = alu_issue_ctrl.
interface alu_issue_if
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);

  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  alu_op_e                  ALUOp;
  logic [2:0]               Funct3;
  logic                     Funct7b5;
  logic                     IsRType;
  logic [DATA_WIDTH-1:0]    SrcA_in;
  logic [DATA_WIDTH-1:0]    SrcB_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic                     Illegal;

  modport master (
    output flush, in_valid, ALUOp, Funct3, Funct7b5, IsRType, SrcA_in, SrcB_in, out_ready,
    input  in_ready, out_valid, Operation, SrcA, SrcB, Illegal
  );

  modport slave (
    input  flush, in_valid, ALUOp, Funct3, Funct7b5, IsRType, SrcA_in, SrcB_in, out_ready,
    output in_ready, out_valid, Operation, SrcA, SrcB, Illegal
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/Funct3/Funct7b5/IsRType -> ALU Operation decoder.
// Undecodable combinations yield OP_ILLEGAL with Illegal set.
module alu_op_decode
  import alu_issue_pkg::*;
#(
  parameter int OPCODE_LENGTH = 4
) (
  input  alu_op_e                  ALUOp,
  input  logic [2:0]               Funct3,
  input  logic                     Funct7b5,
  input  logic                     IsRType,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     Illegal
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    Operation = OP_ILLEGAL;
    Illegal   = 1'b1;
    unique case (ALUOp)
      ALUOP_MEM: begin
        Operation = OP_ADD;
        Illegal   = 1'b0;
      end
      ALUOP_LUI: begin
        Operation = OP_LUI;
        Illegal   = 1'b0;
      end
      ALUOP_BR: begin
        if (Funct3 == 3'b000) begin
          Operation = OP_EQ;
          Illegal   = 1'b0;
        end
      end
      ALUOP_ARITH: begin
        case (Funct3)
          3'b000: begin
            // I-type ADDI reuses bit 30 as immediate, so only R-type may select SUB
            Operation = (IsRType && Funct7b5) ? OP_SUB : OP_ADD;
            Illegal   = 1'b0;
          end
          3'b100: begin
            Operation = OP_XOR;
            Illegal   = 1'b0;
          end
          3'b110: begin
            Operation = OP_OR;
            Illegal   = 1'b0;
          end
          3'b111: begin
            Operation = OP_AND;
            Illegal   = 1'b0;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Registered ALU issue stage: decode on accept, two-entry skid buffer to the ALU.
// Optional saturating issue/illegal counters behind `ALU_ISSUE_STATS_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  alu_issue_if.slave  bus
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0] issued_count,
  output logic [15:0] illegal_count
`endif
);

  logic [OPCODE_LENGTH-1:0] dec_op;
  logic                     dec_illegal;

  alu_op_decode #(
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_decode (
    .ALUOp    (bus.ALUOp),
    .Funct3   (bus.Funct3),
    .Funct7b5 (bus.Funct7b5),
    .IsRType  (bus.IsRType),
    .Operation(dec_op),
    .Illegal  (dec_illegal)
  );

  buf_state_e               state_q;
  logic                     out_valid_q;
  logic                     in_ready_q;
  logic [OPCODE_LENGTH-1:0] head_op_q,  skid_op_q;
  logic                     head_ill_q, skid_ill_q;
  logic [DATA_WIDTH-1:0]    head_a_q,   skid_a_q;
  logic [DATA_WIDTH-1:0]    head_b_q,   skid_b_q;

  logic accept;
  logic pop;

  assign accept = bus.in_valid & in_ready_q;
  assign pop    = out_valid_q & bus.out_ready;

  // in_ready/out_valid are kept as their own flops so neither depends on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath entries are reset as well because Operation/SrcA/SrcB must read zero out of reset.
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      head_op_q   <= '0;
      head_ill_q  <= 1'b0;
      head_a_q    <= '0;
      head_b_q    <= '0;
      skid_op_q   <= '0;
      skid_ill_q  <= 1'b0;
      skid_a_q    <= '0;
      skid_b_q    <= '0;
    end else if (bus.flush) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_op_q   <= dec_op;
            head_ill_q  <= dec_illegal;
            head_a_q    <= bus.SrcA_in;
            head_b_q    <= bus.SrcB_in;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_op_q  <= dec_op;
            head_ill_q <= dec_illegal;
            head_a_q   <= bus.SrcA_in;
            head_b_q   <= bus.SrcB_in;
          end else if (accept) begin
            skid_op_q  <= dec_op;
            skid_ill_q <= dec_illegal;
            skid_a_q   <= bus.SrcA_in;
            skid_b_q   <= bus.SrcB_in;
            state_q    <= TWO;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            head_op_q  <= skid_op_q;
            head_ill_q <= skid_ill_q;
            head_a_q   <= skid_a_q;
            head_b_q   <= skid_b_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Operation = head_op_q;
  assign bus.Illegal   = head_ill_q;
  assign bus.SrcA      = head_a_q;
  assign bus.SrcB      = head_b_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issued_q,  issued_d;
  logic [15:0] illegal_q, illegal_d;

  // A pop in a flush cycle is discarded, so it is not counted either.
  always_comb begin
    issued_d  = issued_q;
    illegal_d = illegal_q;
    if (pop && !bus.flush) begin
      if (issued_q != 16'hFFFF) issued_d = issued_q + 16'd1;
      if (head_ill_q && (illegal_q != 16'hFFFF)) illegal_d = illegal_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q  <= '0;
      illegal_q <= '0;
    end else begin
      issued_q  <= issued_d;
      illegal_q <= illegal_d;
    end
  end

  assign issued_count  = issued_q;
  assign illegal_count = illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus a randomized run
// against a queue-based reference model. Define ALU_ISSUE_STATS_EN to cover the counters.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic        ill;
    logic [31:0] a;
    logic [31:0] b;
  } entry_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  entry_t model_q[$];
  int     m_issued  = 0;
  int     m_illegal = 0;

  alu_issue_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issued_count;
  logic [15:0] illegal_count;
`endif

  alu_issue_ctrl #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .issued_count (issued_count),
    .illegal_count(illegal_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // Reference decode straight from the opcode table: {illegal, operation}.
  function automatic logic [4:0] ref_decode(logic [1:0] aluop, logic [2:0] f3, logic f7, logic rt);
    if (aluop == 2'b00) return {1'b0, 4'b0010};
    if (aluop == 2'b11) return {1'b0, 4'b1001};
    if (aluop == 2'b01) return (f3 == 3'b000) ? {1'b0, 4'b1000} : {1'b1, 4'b1111};
    if (f3 == 3'b000) return {1'b0, (rt && f7) ? 4'b0011 : 4'b0010};
    if (f3 == 3'b100) return {1'b0, 4'b0100};
    if (f3 == 3'b110) return {1'b0, 4'b0001};
    if (f3 == 3'b111) return {1'b0, 4'b0000};
    return {1'b1, 4'b1111};
  endfunction

  task automatic drive_op(logic [1:0] aluop, logic [2:0] f3, logic f7, logic rt,
                          logic [31:0] a, logic [31:0] b);
    bus.ALUOp    = alu_op_e'(aluop);
    bus.Funct3   = f3;
    bus.Funct7b5 = f7;
    bus.IsRType  = rt;
    bus.SrcA_in  = a;
    bus.SrcB_in  = b;
  endtask

  // Advance one clock and move the model the same way: a FIFO of at most two ops.
  task automatic step();
    logic   acc, pp;
    logic [4:0] d;
    entry_t e;
    @(posedge clk);
    if (reset) begin
      model_q.delete();
      m_issued  = 0;
      m_illegal = 0;
    end else if (bus.flush) begin
      model_q.delete();
    end else begin
      acc = bus.in_valid && (model_q.size() < 2);
      pp  = bus.out_ready && (model_q.size() > 0);
      if (pp) begin
        if (m_issued < 65535) m_issued++;
        if (model_q[0].ill && m_illegal < 65535) m_illegal++;
        void'(model_q.pop_front());
      end
      if (acc) begin
        d     = ref_decode(bus.ALUOp, bus.Funct3, bus.Funct7b5, bus.IsRType);
        e.op  = d[3:0];
        e.ill = d[4];
        e.a   = bus.SrcA_in;
        e.b   = bus.SrcB_in;
        model_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_op(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) step();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, expected 0/1", bus.out_valid, bus.in_ready);
    end
    tests++;
    if (bus.Operation !== 4'b0000 || bus.SrcA !== 32'd0 || bus.SrcB !== 32'd0 || bus.Illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_data: op=%b a=%h b=%h ill=%b, expected 0000/0/0/0",
               bus.Operation, bus.SrcA, bus.SrcB, bus.Illegal);
    end
`ifdef ALU_ISSUE_STATS_EN
    tests++;
    if (issued_count !== 16'd0 || illegal_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_stats: issued=%0d illegal=%0d, expected 0/0", issued_count, illegal_count);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_first_op();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive_op(2'b10, 3'b000, 1'b1, 1'b1, 32'd7, 32'd3);
    step();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.Operation !== 4'b0011 || bus.SrcA !== 32'd7 || bus.SrcB !== 32'd3) begin
      fails++;
      $display("FAIL first_op_sub: valid=%b op=%b a=%0d b=%0d, expected 1/0011/7/3",
               bus.out_valid, bus.Operation, bus.SrcA, bus.SrcB);
    end
    drain();
  endtask

  task automatic test_decode_sweep();
    logic [1:0] aluop [9] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    logic [2:0] f3    [9] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b110, 3'b111, 3'b000, 3'b001, 3'b001};
    logic       f7    [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       rt    [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp_op[9] = '{4'b0010, 4'b1000, 4'b1001, 4'b0100, 4'b0001, 4'b0000, 4'b0010,
                              4'b1111, 4'b1111};
    logic       exp_il[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      drive_op(aluop[i], f3[i], f7[i], rt[i], 32'h100 + i, 32'h200 + i);
      step();
      tests++;
      if (bus.out_valid !== 1'b1 || bus.Operation !== exp_op[i] || bus.Illegal !== exp_il[i] ||
          bus.SrcA !== 32'h100 + i) begin
        fails++;
        $display("FAIL decode_%0d: valid=%b op=%b ill=%b a=%h, expected 1/%b/%b/%h",
                 i, bus.out_valid, bus.Operation, bus.Illegal, bus.SrcA, exp_op[i], exp_il[i], 32'h100 + i);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    int k = 0;
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc == 2) begin
        tests++;
        if (bus.in_ready !== 1'b0 || bus.SrcA !== 32'd100) begin
          fails++;
          $display("FAIL bp_full: in_ready=%b head=%0d, expected 0/100", bus.in_ready, bus.SrcA);
        end
      end
      if (cyc == 3) begin
        tests++;
        if (k !== 2 || bus.SrcA !== 32'd100 || bus.out_valid !== 1'b1) begin
          fails++;
          $display("FAIL bp_stall: accepted=%0d head=%0d valid=%b, expected 2/100/1", k, bus.SrcA, bus.out_valid);
        end
        bus.out_ready = 1'b1;
      end
      bus.in_valid = (k < 3);
      drive_op(2'b10, 3'(3'b100 + k), 1'b0, 1'b1, 32'd100 * (k + 1), 32'd1);
      if (bus.out_valid && bus.out_ready) got.push_back(bus.SrcA);
      if (bus.in_valid && bus.in_ready) k++;
      step();
    end
    tests++;
    if (got.size() !== 3) begin
      fails++;
      $display("FAIL bp_count: popped=%0d, expected 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (got[i] !== 32'd100 * (i + 1)) begin
          fails++;
          $display("FAIL bp_order_%0d: got %0d, expected %0d", i, got[i], 100 * (i + 1));
        end
      end
    end
    drain();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive_op(2'b00, 3'b000, 1'b0, 1'b0, 32'hA1, 32'd0);
    step();
    drive_op(2'b11, 3'b000, 1'b0, 1'b0, 32'hA2, 32'd0);
    step();
    bus.flush = 1'b1;
    drive_op(2'b01, 3'b000, 1'b0, 1'b0, 32'hA3, 32'd0);
    step();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_two: out_valid=%b in_ready=%b, expected 0/1", bus.out_valid, bus.in_ready);
    end
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL flush_leak_%0d: out_valid=%b a=%h, expected 0", i, bus.out_valid, bus.SrcA);
      end
    end
    // Flush while ONE with a same-cycle accept: the new op must vanish too.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive_op(2'b00, 3'b000, 1'b0, 1'b0, 32'hB1, 32'd0);
    step();
    bus.flush = 1'b1;
    drive_op(2'b00, 3'b000, 1'b0, 1'b0, 32'hB2, 32'd0);
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    step();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_accept: out_valid=%b in_ready=%b a=%h, expected 0/1", bus.out_valid, bus.in_ready, bus.SrcA);
    end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      drive_op(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
      step();
      tests++;
      if (bus.out_valid !== (model_q.size() > 0) || bus.in_ready !== (model_q.size() < 2)) begin
        fails++;
        $display("FAIL rand_hs_%0d: out_valid=%b in_ready=%b, expected %b/%b",
                 n, bus.out_valid, bus.in_ready, model_q.size() > 0, model_q.size() < 2);
      end else if (model_q.size() > 0) begin
        tests++;
        if (bus.Operation !== model_q[0].op || bus.Illegal !== model_q[0].ill ||
            bus.SrcA !== model_q[0].a || bus.SrcB !== model_q[0].b) begin
          fails++;
          $display("FAIL rand_data_%0d: op=%b ill=%b a=%h b=%h, expected %b/%b/%h/%h", n,
                   bus.Operation, bus.Illegal, bus.SrcA, bus.SrcB,
                   model_q[0].op, model_q[0].ill, model_q[0].a, model_q[0].b);
        end
      end
`ifdef ALU_ISSUE_STATS_EN
      tests++;
      if (issued_count !== 16'(m_issued) || illegal_count !== 16'(m_illegal)) begin
        fails++;
        $display("FAIL rand_stats_%0d: issued=%0d illegal=%0d, expected %0d/%0d",
                 n, issued_count, illegal_count, m_issued, m_illegal);
      end
`endif
    end
    bus.flush = 1'b0;
    drain();
  endtask

`ifdef ALU_ISSUE_STATS_EN
  task automatic test_stats();
    logic [2:0] f3[5] = '{3'b000, 3'b001, 3'b100, 3'b010, 3'b111};
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      drive_op(2'b10, f3[i], 1'b0, 1'b1, 32'(i), 32'd0);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (2) step();
    tests++;
    if (issued_count !== 16'd5 || illegal_count !== 16'd2) begin
      fails++;
      $display("FAIL stats_count: issued=%0d illegal=%0d, expected 5/2", issued_count, illegal_count);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (issued_count !== 16'd0 || illegal_count !== 16'd0) begin
      fails++;
      $display("FAIL stats_reset: issued=%0d illegal=%0d, expected 0/0", issued_count, illegal_count);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_first_op();
    test_decode_sweep();
    test_backpressure();
    test_flush();
    test_random();
`ifdef ALU_ISSUE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
